isw_and_pipe: RTL and testbench

ISW_AND_PIPE -- requirements
Module: isw_and_pipe

---
 rtl/isw_pkg.sv | 14 +
 rtl/isw_pipe_ctrl.sv | 32 +++
 rtl/isw_and_pipe.sv | 88 ++++++++
 tb/tb_isw_and_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/isw_pkg.sv
// Shared sizing helpers for the ISW masked-AND pipeline: random-word count
// and the lexicographic pair (i<j) to random-word index mapping.
package isw_pkg;

  function automatic int nrand(input int n);
    return n * (n - 1) / 2;
  endfunction

  // (0,1),(0,2)..(0,n-1),(1,2).. -> 0,1,2,..
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/isw_pipe_ctrl.sv
// Valid/enable control for the two-stage elastic pipeline.
// The data path follows the e1/e2 enables produced here.
module isw_pipe_ctrl (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic ready_i,
  output logic ready_o,
  output logic valid_o,
  output logic e1,
  output logic e2
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;

  // A stage may load when it is empty or its contents move on this edge.
  assign e2      = !vld_pipe[2] || ready_i;
  assign e1      = !vld_pipe[1] || e2;
  assign ready_o = e1;
  assign valid_o = vld_pipe[2];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
    end else begin
      if (e1) vld_pipe[1] <= valid_i;
      if (e2) vld_pipe[2] <= vld_pipe[1];
    end
  end

endmodule

// File: rtl/isw_and_pipe.sv
// Two-stage pipelined ISW masked AND: Q = X & Y over NSHARES Boolean shares.
// Cross products are registered before any share combination.
module isw_and_pipe
  import isw_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NSHARES = 2,
  localparam int NRAND   = nrand(NSHARES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [NSHARES*WIDTH-1:0]   x_i,
  input  logic [NSHARES*WIDTH-1:0]   y_i,
  input  logic [NRAND*WIDTH-1:0]     r_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [NSHARES*WIDTH-1:0]   q_o
);
  logic e1, e2;

  logic [NSHARES-1:0][WIDTH-1:0] xs, ys, d_d, d_q, c_d, c_q;
  logic [NRAND-1:0][WIDTH-1:0]   rs, t_d, t_q, u_d, u_q, r_q;

  assign xs = x_i;
  assign ys = y_i;
  assign rs = r_i;

  isw_pipe_ctrl u_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .e1      (e1),
    .e2      (e2)
  );

  // Stage 1: only products and the fresh mask on t; t and u stay separate
  // so no partially unmasked share exists before the register.
  always_comb begin
    d_d = '0;
    t_d = '0;
    u_d = '0;
    for (int i = 0; i < NSHARES; i++) begin
      d_d[i] = xs[i] & ys[i];
      for (int j = i + 1; j < NSHARES; j++) begin
        t_d[pair_idx(i, j, NSHARES)] = rs[pair_idx(i, j, NSHARES)] ^ (xs[i] & ys[j]);
        u_d[pair_idx(i, j, NSHARES)] = xs[j] & ys[i];
      end
    end
  end

  // Stage 2: share i absorbs r_ij for j>i and the masked pair (t_ji ^ u_ji) for j<i.
  always_comb begin
    c_d = '0;
    for (int i = 0; i < NSHARES; i++) begin
      c_d[i] = d_q[i];
      for (int j = i + 1; j < NSHARES; j++)
        c_d[i] = c_d[i] ^ r_q[pair_idx(i, j, NSHARES)];
      for (int j = 0; j < i; j++)
        c_d[i] = c_d[i] ^ t_q[pair_idx(j, i, NSHARES)] ^ u_q[pair_idx(j, i, NSHARES)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q <= '0;
      t_q <= '0;
      u_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      if (e1) begin
        d_q <= d_d;
        t_q <= t_d;
        u_q <= u_d;
        r_q <= rs;
      end
      if (e2) c_q <= c_d;
    end
  end

  assign q_o = c_q;

endmodule

// File: tb/tb_isw_and_pipe.sv
// Directed and random checks of isw_and_pipe with 2 and 3 shares.
module tb_isw_and_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // two-share instance
  logic        v2, rdy2, vo2, ri2;
  logic [15:0] x2, y2, q2;
  logic [7:0]  r2;

  isw_and_pipe #(.WIDTH(8), .NSHARES(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(rdy2),
    .x_i(x2), .y_i(y2), .r_i(r2), .valid_o(vo2), .ready_i(ri2), .q_o(q2)
  );

  // three-share instance
  logic        v3, rdy3, vo3, ri3;
  logic [23:0] x3, y3, r3, q3;

  isw_and_pipe #(.WIDTH(8), .NSHARES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(rdy3),
    .x_i(x3), .y_i(y3), .r_i(r3), .valid_o(vo3), .ready_i(ri3), .q_o(q3)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [15:0] q;
  } vec_t;

  vec_t vt[8];
  int tot = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive2(input int k);
    x2 = vt[k].x;
    y2 = vt[k].y;
    r2 = vt[k].r;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] expq[$];
  logic [7:0] ex, ax, ay;
  int cnt;

  initial begin
    // shares packed {share1, share0}; q hand-computed
    vt[0] = '{16'h3CF0, 16'h0FAA, 8'h5A, 16'h7EFA};
    vt[1] = '{16'hFFFF, 16'h3412, 8'h00, 16'h1212};
    vt[2] = '{16'hFFFF, 16'h3412, 8'hC3, 16'hD1D1};
    vt[3] = '{16'h0000, 16'hFFFF, 8'hA5, 16'hA5A5};
    vt[4] = '{16'h0055, 16'h000F, 8'h00, 16'h0005};
    vt[5] = '{16'hFF00, 16'h00FF, 8'h0F, 16'hF00F};
    vt[6] = '{16'h4281, 16'h1824, 8'h99, 16'h9999};
    vt[7] = '{16'h00AB, 16'h00CD, 8'h11, 16'h1198};

    rst_n = 1'b0; v2 = 1'b0; ri2 = 1'b1; x2 = '0; y2 = '0; r2 = '0;
    v3 = 1'b0; ri3 = 1'b1; x3 = '0; y3 = '0; r3 = '0;
    step; step;
    chk("rst_vo", {31'd0, vo2}, 32'd0);
    chk("rst_q", {16'd0, q2}, 32'd0);
    chk("rst_vo3", {31'd0, vo3}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", {31'd0, rdy2}, 32'd1);

    // single operations: two-cycle latency and value
    for (int k = 0; k < 8; k++) begin
      drive2(k); v2 = 1'b1;
      step;
      chk($sformatf("lat1_%0d", k), {31'd0, vo2}, 32'd0);
      v2 = 1'b0;
      step;
      chk($sformatf("vo_%0d", k), {31'd0, vo2}, 32'd1);
      chk($sformatf("q_%0d", k), {16'd0, q2}, {16'd0, vt[k].q});
      step;
      chk($sformatf("drain_%0d", k), {31'd0, vo2}, 32'd0);
    end

    // back-to-back stream
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin drive2((k * 3) % 8); v2 = 1'b1; end
      else v2 = 1'b0;
      step;
      if (k >= 1 && k <= 4) begin
        chk($sformatf("strm_vo_%0d", k), {31'd0, vo2}, 32'd1);
        chk($sformatf("strm_q_%0d", k), {16'd0, q2}, {16'd0, vt[((k - 1) * 3) % 8].q});
      end else if (k == 5) begin
        chk("strm_end", {31'd0, vo2}, 32'd0);
      end
    end

    // stall with a full pipeline, release with simultaneous handshakes
    drive2(1); v2 = 1'b1; step;
    drive2(2); step;
    chk("fill_vo", {31'd0, vo2}, 32'd1);
    drive2(3); ri2 = 1'b0;
    #1;
    chk("stall_rdy0", {31'd0, rdy2}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      step;
      chk($sformatf("stall_vo_%0d", s), {31'd0, vo2}, 32'd1);
      chk($sformatf("stall_q_%0d", s), {16'd0, q2}, {16'd0, vt[1].q});
      chk($sformatf("stall_rdy_%0d", s), {31'd0, rdy2}, 32'd0);
    end
    ri2 = 1'b1;
    #1;
    chk("rel_rdy", {31'd0, rdy2}, 32'd1);
    step;
    chk("rel_q1", {16'd0, q2}, {16'd0, vt[2].q});
    v2 = 1'b0;
    step;
    chk("rel_vo2", {31'd0, vo2}, 32'd1);
    chk("rel_q2", {16'd0, q2}, {16'd0, vt[3].q});
    step;
    chk("rel_end", {31'd0, vo2}, 32'd0);

    // reset with two operations in flight
    drive2(5); v2 = 1'b1; step;
    drive2(6); step;
    rst_n = 1'b0; v2 = 1'b0;
    step;
    chk("mrst_vo", {31'd0, vo2}, 32'd0);
    chk("mrst_q", {16'd0, q2}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_rdy", {31'd0, rdy2}, 32'd1);
    cnt = 0;
    for (int s = 0; s < 3; s++) begin
      step;
      if (vo2) cnt++;
    end
    chk("mrst_stale", cnt, 0);

    // X = 0 with random Y and masks: recombined Q must be zero
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        x2 = 16'hFFFF; y2 = 16'($urandom); r2 = 8'($urandom); v2 = 1'b1;
      end else v2 = 1'b0;
      step;
      if (vo2) begin
        cnt++;
        chk($sformatf("x0_q_%0d", cnt), {24'd0, q2[7:0] ^ q2[15:8]}, 32'd0);
      end
    end
    chk("x0_cnt", cnt, 8);

    // three shares, 1000 random operations through a queue scoreboard
    cnt = 0;
    for (int k = 0; k < 1004; k++) begin
      if (k < 1000) begin
        x3 = 24'($urandom); y3 = 24'($urandom); r3 = 24'($urandom); v3 = 1'b1;
        ax = x3[7:0] ^ x3[15:8] ^ x3[23:16];
        ay = y3[7:0] ^ y3[15:8] ^ y3[23:16];
        if (rdy3) expq.push_back(ax & ay);
      end else v3 = 1'b0;
      step;
      if (vo3) begin
        if (expq.size() == 0) begin
          chk("n3_extra", 32'd1, 32'd0);
        end else begin
          ex = expq.pop_front();
          cnt++;
          chk($sformatf("n3_%0d", cnt), {24'd0, q3[7:0] ^ q3[15:8] ^ q3[23:16]}, {24'd0, ex});
        end
      end
    end
    chk("n3_cnt", cnt, 1000);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
